// File: rtl/updown_mod_counter.sv
// Up/down counter with a programmable modulus, synchronous load, and wrap or saturate limit handling.
// It produces a registered terminal-count pulse and a sticky limit flag.
module updown_mod_counter #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] modulus,
    input  logic             sat_mode,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             limit_sticky
);

    localparam logic [WIDTH-1:0] RST_CNT = RESET_VALUE[WIDTH-1:0];

    // A load larger than the modulus is clamped to the modulus.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v,
                                                    input logic [WIDTH-1:0] m);
        return (v <= m) ? v : m;
    endfunction

    // Computes one enabled step. The result is {limit event, next count}.
    function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] c,
                                            input logic             dir_up,
                                            input logic [WIDTH-1:0] m,
                                            input logic             sat);
        logic             hit;
        logic [WIDTH-1:0] nxt;
        hit = 1'b0;
        if (dir_up) begin
            if (c >= m) begin
                hit = 1'b1;
                nxt = sat ? m : '0;
            end else begin
                nxt = c + 1'b1;
            end
        end else begin
            if (c == '0) begin
                hit = 1'b1;
                nxt = sat ? '0 : m;
            end else if (c > m && sat) begin
                // The modulus was lowered below count: snap to the modulus. This is not a limit event.
                nxt = m;
            end else begin
                nxt = c - 1'b1;
            end
        end
        return {hit, nxt};
    endfunction

    logic [WIDTH-1:0] cnt_next;
    logic             tc_next;

    always_comb begin
        cnt_next = count;
        tc_next  = 1'b0;
        if (load) begin
            cnt_next = clamp_load(load_value, modulus);
        end else if (en) begin
            {tc_next, cnt_next} = step(count, up, modulus, sat_mode);
        end
    end

    // Register stage: every output updates one cycle after the qualifying edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= RST_CNT;
            tc           <= 1'b0;
            limit_sticky <= 1'b0;
        end else begin
            count        <= cnt_next;
            tc           <= tc_next;
            limit_sticky <= tc_next | (limit_sticky & ~clr_sticky);
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter: directed scenarios from the test plan plus a randomized
// run, all checked against an integer reference model.
module tb_updown_mod_counter;

    localparam int W  = 4;
    localparam int RV = 0;

    logic         clk = 1'b0;
    logic         reset, en, up, load, sat_mode, clr_sticky;
    logic [W-1:0] load_value, modulus;
    logic [W-1:0] count;
    logic         tc, limit_sticky;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt = RV;
    int m_tc  = 0;
    int m_st  = 0;

    updown_mod_counter #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_value(load_value), .modulus(modulus), .sat_mode(sat_mode),
        .clr_sticky(clr_sticky), .count(count), .tc(tc), .limit_sticky(limit_sticky)
    );

    always #5 clk = ~clk;

    // Advance one clock. The model applies the rules to the inputs sampled at this edge,
    // and outputs are observed 1 time unit after the edge.
    task automatic tick();
        int mod, nc, ntc;
        @(posedge clk);
        mod = int'(modulus);
        nc  = m_cnt;
        ntc = 0;
        if (reset) begin
            m_cnt = RV; m_tc = 0; m_st = 0;
        end else begin
            if (load) begin
                nc = (int'(load_value) > mod) ? mod : int'(load_value);
            end else if (en && up) begin
                if (m_cnt >= mod) begin ntc = 1; nc = sat_mode ? mod : 0; end
                else nc = m_cnt + 1;
            end else if (en) begin
                if (m_cnt == 0) begin ntc = 1; nc = sat_mode ? 0 : mod; end
                else if (m_cnt > mod) nc = sat_mode ? mod : m_cnt - 1;
                else nc = m_cnt - 1;
            end
            m_st  = (ntc == 1 || (m_st == 1 && !clr_sticky)) ? 1 : 0;
            m_cnt = nc;
            m_tc  = ntc;
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; en = 0; up = 1; load = 0; sat_mode = 0; clr_sticky = 0;
        load_value = '0; modulus = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; modulus = 4'd9;
        tick(); tick();
        reset = 0;
        checks++;
        if (count !== 4'(RV) || tc !== 1'b0 || limit_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0d tc=%0b sticky=%0b, required count=%0d tc=0 sticky=0",
                     count, tc, limit_sticky, RV);
        end
    endtask

    task automatic test_up_wrap();
        en = 1; up = 1; sat_mode = 0; modulus = 4'd9;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (count !== 4'(i % 10) || tc !== (i == 10)) begin
                errors++;
                $display("FAIL up_wrap step %0d: count=%0d tc=%0b, required count=%0d tc=%0b",
                         i, count, tc, i % 10, (i == 10));
            end
        end
        en = 0;
        tick();
        checks++;
        if (limit_sticky !== 1'b1 || tc !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap sticky: sticky=%0b tc=%0b, required sticky=1 tc=0", limit_sticky, tc);
        end
    endtask

    task automatic test_down_wrap();
        int exp_c[7] = '{3, 2, 1, 1, 1, 0, 5};
        int exp_t[7] = '{0, 0, 0, 0, 0, 0, 1};
        modulus = 4'd5; load_value = 4'd3; load = 1; en = 0; up = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) load = 0;
            en = (i == 0 || i == 3 || i == 4) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (count !== 4'(exp_c[i]) || tc !== exp_t[i][0]) begin
                errors++;
                $display("FAIL down_wrap step %0d: count=%0d tc=%0b, required count=%0d tc=%0b",
                         i, count, tc, exp_c[i], exp_t[i]);
            end
        end
        tick();
        checks++;
        if (count !== 4'd4 || tc !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap tail: count=%0d tc=%0b, required count=4 tc=0", count, tc);
        end
        en = 0;
    endtask

    task automatic test_saturate();
        modulus = 4'd15; sat_mode = 1; load_value = 4'd14; load = 1;
        tick();
        load = 0; en = 1; up = 1;
        tick();
        checks++;
        if (count !== 4'd15 || tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_reach: count=%0d tc=%0b, required count=15 tc=0", count, tc);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (count !== 4'd15 || tc !== 1'b1) begin
                errors++;
                $display("FAIL sat_hold %0d: count=%0d tc=%0b, required count=15 tc=1", i, count, tc);
            end
        end
        up = 0;
        tick();
        checks++;
        if (count !== 4'd14 || tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_leave: count=%0d tc=%0b, required count=14 tc=0", count, tc);
        end
        en = 0; sat_mode = 0;
    endtask

    task automatic test_load_priority();
        modulus = 4'd6; load_value = 4'd12; load = 1; en = 1; up = 1;
        tick();
        checks++;
        if (count !== 4'd6 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: count=%0d tc=%0b, required count=6 tc=0", count, tc);
        end
        reset = 1;
        tick();
        reset = 0; load = 0; en = 0;
        checks++;
        if (count !== 4'(RV) || tc !== 1'b0 || limit_sticky !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_load: count=%0d tc=%0b sticky=%0b, required count=%0d tc=0 sticky=0",
                     count, tc, limit_sticky, RV);
        end
    endtask

    task automatic test_modulus_drop();
        modulus = 4'd15; load_value = 4'd12; load = 1;
        tick();
        load = 0; modulus = 4'd4; en = 1; up = 1; sat_mode = 0;
        tick();
        checks++;
        if (count !== 4'd0 || tc !== 1'b1) begin
            errors++;
            $display("FAIL drop_up_wrap: count=%0d tc=%0b, required count=0 tc=1", count, tc);
        end
        en = 0; modulus = 4'd15; load = 1;
        tick();
        load = 0; modulus = 4'd4; en = 1; up = 0; sat_mode = 1;
        tick();
        checks++;
        if (count !== 4'd4 || tc !== 1'b0) begin
            errors++;
            $display("FAIL drop_down_sat: count=%0d tc=%0b, required count=4 tc=0", count, tc);
        end
        en = 0; sat_mode = 0;
    endtask

    task automatic test_sticky();
        modulus = 4'd0; en = 1; up = 1; clr_sticky = 1;
        tick();
        checks++;
        if (limit_sticky !== 1'b1 || tc !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins: sticky=%0b tc=%0b, required sticky=1 tc=1", limit_sticky, tc);
        end
        en = 0;
        tick();
        checks++;
        if (limit_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear: sticky=%0b, required 0", limit_sticky);
        end
        clr_sticky = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            up = i[0]; sat_mode = i[1];
            tick();
            checks++;
            if (count !== 4'd0 || tc !== 1'b1) begin
                errors++;
                $display("FAIL mod_zero %0d: count=%0d tc=%0b, required count=0 tc=1", i, count, tc);
            end
        end
        en = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            load       = ($urandom_range(0, 9) == 0);
            en         = ($urandom_range(0, 3) != 0);
            up         = $urandom_range(0, 1) != 0;
            sat_mode   = $urandom_range(0, 1) != 0;
            clr_sticky = ($urandom_range(0, 7) == 0);
            load_value = W'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) modulus = W'($urandom_range(0, 15));
            tick();
            checks++;
            if (count !== W'(m_cnt) || tc !== m_tc[0] || limit_sticky !== m_st[0]) begin
                errors++;
                $display("FAIL random %0d: count=%0d tc=%0b sticky=%0b, required count=%0d tc=%0d sticky=%0d",
                         i, count, tc, limit_sticky, m_cnt, m_tc, m_st);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_modulus_drop();
        test_sticky();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
